// File: rtl/cpu_pkg.sv
// Shared encodings for the register-file + ALU datapath and its command sequencer.
package cpu_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] OP_ALU  = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_READ = 2'd2;
  localparam logic [1:0] OP_CMP  = 2'd3;

  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_EXEC = 3'd2;
  localparam logic [2:0] ST_WB   = 3'd3;
  localparam logic [2:0] ST_RSP  = 3'd4;

  // Function codes understood by the datapath ALU.
  localparam logic [2:0] ALUC_ADD = 3'd0;
  localparam logic [2:0] ALUC_SUB = 3'd1;
  localparam logic [2:0] ALUC_AND = 3'd2;
  localparam logic [2:0] ALUC_OR  = 3'd3;
  localparam logic [2:0] ALUC_XOR = 3'd4;
  localparam logic [2:0] ALUC_SLL = 3'd5;
  localparam logic [2:0] ALUC_SRL = 3'd6;
  localparam logic [2:0] ALUC_SLT = 3'd7;

  typedef struct packed {
    logic [1:0]        op;
    logic [2:0]        aluc;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [REG_AW-1:0] rw;
  } cmd_t;

  // r0 is hard-wired to zero unless the datapath allows writing it.
  function automatic logic wb_allowed(input logic [REG_AW-1:0] rw, input bit r0_writable);
    return (rw != '0) || r0_writable;
  endfunction

endpackage

// File: rtl/rf_alu_seq.sv
// Command sequencer driving the register-file + ALU datapath over a fixed
// multi-cycle schedule, with a zeroing sweep of the register file after reset.
module rf_alu_seq
  import cpu_pkg::*;
#(
  parameter int NREG        = 32,
  parameter bit INIT_EN     = 1'b1,
  parameter bit R0_WRITABLE = 1'b0,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [2:0]        cmd_aluc,
  input  logic [4:0]        cmd_ra,
  input  logic [4:0]        cmd_rb,
  input  logic [4:0]        cmd_rw,
  input  logic [31:0]       cmd_data,
  output logic [4:0]        dp_ra,
  output logic [4:0]        dp_rb,
  output logic [4:0]        dp_rw,
  output logic [2:0]        dp_aluc,
  output logic              dp_we,
  output logic              dp_mux3,
  output logic [31:0]       dp_rd,
  input  logic [31:0]       dp_qa,
  input  logic [31:0]       dp_qb,
  input  logic [31:0]       dp_alu_out,
  input  logic              dp_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_zero,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt
);

  localparam logic [REG_AW-1:0] LAST_REG = REG_AW'(NREG - 1);

  logic [2:0]        state_q, state_d;
  logic [REG_AW-1:0] cnt_q, cnt_d;
  cmd_t              cmd_q, cmd_d;
  logic [31:0]       res_q, res_d;
  logic              zero_q, zero_d;
  logic [CNT_W-1:0]  done_q, done_d;
  logic              we_raw;
  logic              qb_unused;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    res_d   = res_q;
    zero_d  = zero_q;
    done_d  = done_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + REG_AW'(1);
        if (cnt_q == LAST_REG) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d = '{op: cmd_op, aluc: cmd_aluc, ra: cmd_ra, rb: cmd_rb, rw: cmd_rw};
          if (cmd_op == OP_LOAD) begin
            res_d   = cmd_data;
            zero_d  = 1'b0;
            state_d = ST_WB;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (cmd_q.op == OP_READ) begin
          res_d  = dp_qa;
          zero_d = 1'b0;
        end else begin
          res_d  = dp_alu_out;
          zero_d = dp_zero;
        end
        state_d = (cmd_q.op == OP_ALU) ? ST_WB : ST_RSP;
      end
      ST_WB: state_d = ST_RSP;
      ST_RSP: begin
        if (rsp_ready) begin
          done_d  = done_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= INIT_EN ? ST_INIT : ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    we_raw = 1'b0;
    case (state_q)
      ST_INIT: we_raw = wb_allowed(cnt_q, R0_WRITABLE);
      ST_WB:   we_raw = wb_allowed(cmd_q.rw, R0_WRITABLE);
      default: we_raw = 1'b0;
    endcase
  end

  // Gating with clr keeps a write from landing on the same edge that resets the sequencer.
  assign dp_we     = we_raw & clr;
  assign dp_mux3   = 1'b0;
  assign dp_ra     = cmd_q.ra;
  assign dp_rb     = cmd_q.rb;
  assign dp_aluc   = cmd_q.aluc;
  assign dp_rw     = (state_q == ST_INIT) ? cnt_q : cmd_q.rw;
  assign dp_rd     = (state_q == ST_WB) ? res_q : 32'd0;

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_data  = res_q;
  assign rsp_zero  = zero_q;
  assign busy      = (state_q != ST_IDLE);
  assign done_cnt  = done_q;

  // Operand B only feeds the ALU outside this block.
  assign qb_unused = ^dp_qb;

endmodule

// File: tb/tb_rf_alu_seq.sv
// Directed bench: wraps the sequencer with a behavioural register file and ALU.
module tb_rf_alu_seq;
  import cpu_pkg::*;

  logic        clk;
  logic        clr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_aluc;
  logic [4:0]  cmd_ra, cmd_rb, cmd_rw;
  logic [31:0] cmd_data;
  logic [4:0]  dp_ra, dp_rb, dp_rw;
  logic [2:0]  dp_aluc;
  logic        dp_we, dp_mux3;
  logic [31:0] dp_rd, dp_qa, dp_qb, dp_alu_out;
  logic        dp_zero;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic        busy;
  logic [15:0] done_cnt;

  int nAssert = 0;
  int nFail   = 0;
  int weCount = 0;

  logic [31:0] rf [0:31] = '{default: 32'hA5A5_5A5A};

  rf_alu_seq dut (
    .clk(clk), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_aluc(cmd_aluc),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rw(cmd_rw), .cmd_data(cmd_data),
    .dp_ra(dp_ra), .dp_rb(dp_rb), .dp_rw(dp_rw), .dp_aluc(dp_aluc),
    .dp_we(dp_we), .dp_mux3(dp_mux3), .dp_rd(dp_rd),
    .dp_qa(dp_qa), .dp_qb(dp_qb), .dp_alu_out(dp_alu_out), .dp_zero(dp_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .busy(busy), .done_cnt(done_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file: r0 always reads zero, writes land on the rising edge.
  always @(posedge clk) begin
    if (dp_we) begin
      rf[dp_rw] <= dp_mux3 ? dp_alu_out : dp_rd;
      weCount   <= weCount + 1;
    end
  end

  assign dp_qa = (dp_ra == 5'd0) ? 32'd0 : rf[dp_ra];
  assign dp_qb = (dp_rb == 5'd0) ? 32'd0 : rf[dp_rb];

  always_comb begin
    dp_alu_out = 32'd0;
    case (dp_aluc)
      ALUC_ADD: dp_alu_out = dp_qa + dp_qb;
      ALUC_SUB: dp_alu_out = dp_qa - dp_qb;
      ALUC_AND: dp_alu_out = dp_qa & dp_qb;
      ALUC_OR:  dp_alu_out = dp_qa | dp_qb;
      ALUC_XOR: dp_alu_out = dp_qa ^ dp_qb;
      ALUC_SLL: dp_alu_out = dp_qa << dp_qb[4:0];
      ALUC_SRL: dp_alu_out = dp_qa >> dp_qb[4:0];
      ALUC_SLT: dp_alu_out = {31'd0, $signed(dp_qa) < $signed(dp_qb)};
      default:  dp_alu_out = 32'd0;
    endcase
  end
  assign dp_zero = (dp_alu_out == 32'd0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAssert++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Offers one command in IDLE and waits for rsp_valid, checking latency and payload.
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [2:0] aluc,
                               input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                               input logic [31:0] data, input int expLat,
                               input logic [31:0] expData, input logic expZero);
    int lat;
    checkOutput({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_op = op; cmd_aluc = aluc; cmd_ra = ra; cmd_rb = rb; cmd_rw = rw; cmd_data = data;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_data"}, rsp_data, expData);
    checkOutput({tag, "_zero"}, 32'(rsp_zero), 32'(expZero));
  endtask

  task automatic finishRsp(input string tag, input int expDone);
    tick();
    checkOutput({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_done_cnt"}, 32'(done_cnt), 32'(expDone));
    checkOutput({tag, "_ready_next"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int weHigh, readyHigh, validHigh, r0We, wcBefore;
    logic [31:0] rfOr;

    clr = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_op = '0; cmd_aluc = '0; cmd_ra = '0; cmd_rb = '0; cmd_rw = '0; cmd_data = '0;
    tick();
    tick();
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'd0);
    checkOutput("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    checkOutput("rst_done_cnt", 32'(done_cnt), 32'd0);
    checkOutput("rst_dp_we", 32'(dp_we), 32'd0);
    checkOutput("rst_dp_rd", dp_rd, 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd1);

    // Init sweep: 32 cycles with cmd_ready low, writes to r1..r31 only.
    clr = 1'b1;
    weHigh = 0; readyHigh = 0; r0We = 0;
    for (int i = 0; i < 32; i++) begin
      readyHigh += int'(cmd_ready);
      weHigh    += int'(dp_we);
      if (i == 0) r0We = int'(dp_we);
      tick();
    end
    checkOutput("init_ready_cycles", 32'(readyHigh), 32'd0);
    checkOutput("init_we_pulses", 32'(weHigh), 32'd31);
    checkOutput("init_r0_we", 32'(r0We), 32'd0);
    checkOutput("init_done_ready", 32'(cmd_ready), 32'd1);
    checkOutput("init_busy_low", 32'(busy), 32'd0);
    rfOr = 32'd0;
    for (int i = 1; i < 32; i++) rfOr |= rf[i];
    checkOutput("init_rf_zeroed", rfOr, 32'd0);

    applyStimulus("read_r5", OP_READ, ALUC_ADD, 5'd5, 5'd0, 5'd0, 32'd0, 2, 32'd0, 1'b0);
    finishRsp("read_r5", 1);

    applyStimulus("load_r3", OP_LOAD, ALUC_ADD, 5'd0, 5'd0, 5'd3, 32'h0000_0007, 2, 32'd7, 1'b0);
    finishRsp("load_r3", 2);
    applyStimulus("load_r4", OP_LOAD, ALUC_ADD, 5'd0, 5'd0, 5'd4, 32'h0000_0005, 2, 32'd5, 1'b0);
    finishRsp("load_r4", 3);

    applyStimulus("alu_add", OP_ALU, ALUC_ADD, 5'd3, 5'd4, 5'd6, 32'd0, 3, 32'd12, 1'b0);
    finishRsp("alu_add", 4);
    checkOutput("alu_add_rf6", rf[6], 32'd12);
    applyStimulus("read_r6", OP_READ, ALUC_ADD, 5'd6, 5'd0, 5'd0, 32'd0, 2, 32'd12, 1'b0);
    finishRsp("read_r6", 5);

    wcBefore = weCount;
    applyStimulus("cmp_sub", OP_CMP, ALUC_SUB, 5'd3, 5'd3, 5'd7, 32'd0, 2, 32'd0, 1'b1);
    finishRsp("cmp_sub", 6);
    checkOutput("cmp_no_write", 32'(weCount), 32'(wcBefore));

    applyStimulus("load_r0", OP_LOAD, ALUC_ADD, 5'd0, 5'd0, 5'd0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 1'b0);
    finishRsp("load_r0", 7);
    checkOutput("load_r0_no_write", 32'(weCount), 32'(wcBefore));
    applyStimulus("read_r0", OP_READ, ALUC_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 2, 32'd0, 1'b0);
    finishRsp("read_r0", 8);

    // Response back-pressure: everything holds until rsp_ready returns.
    rsp_ready = 1'b0;
    applyStimulus("bp_read_r3", OP_READ, ALUC_ADD, 5'd3, 5'd0, 5'd0, 32'd0, 2, 32'd7, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_valid_hold", 32'(rsp_valid), 32'd1);
      checkOutput("bp_data_hold", rsp_data, 32'd7);
      checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("bp_done_hold", 32'(done_cnt), 32'd8);
    end
    rsp_ready = 1'b1;
    finishRsp("bp_read_r3", 9);

    // Reset lands during WB of an ALU command targeting r9.
    cmd_op = OP_ALU; cmd_aluc = ALUC_ADD; cmd_ra = 5'd3; cmd_rb = 5'd4; cmd_rw = 5'd9;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    checkOutput("wb_dp_we", 32'(dp_we), 32'd1);
    checkOutput("wb_dp_rw", 32'(dp_rw), 32'd9);
    checkOutput("wb_dp_rd", dp_rd, 32'd12);
    clr = 1'b0;
    #1;
    checkOutput("clr_wb_we_blocked", 32'(dp_we), 32'd0);
    tick();
    checkOutput("clr_rf9_unwritten", rf[9], 32'd0);
    checkOutput("clr_done_cnt", 32'(done_cnt), 32'd0);
    checkOutput("clr_busy", 32'(busy), 32'd1);
    clr = 1'b1;
    validHigh = 0; readyHigh = 0;
    for (int i = 0; i < 32; i++) begin
      validHigh += int'(rsp_valid);
      readyHigh += int'(cmd_ready);
      tick();
    end
    checkOutput("clr_rsp_never", 32'(validHigh), 32'd0);
    checkOutput("clr_reinit_ready_low", 32'(readyHigh), 32'd0);
    checkOutput("clr_reinit_idle", 32'(cmd_ready), 32'd1);
    checkOutput("clr_done_after", 32'(done_cnt), 32'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
